dz_scan_ctrl: RTL and testbench



---
 rtl/dz_pkg.sv | 21 ++
 rtl/dz_scan_ctrl_if.sv | 21 ++
 rtl/dz_glyph_rom.sv | 10 +
 rtl/dz_scan_ctrl.sv | 94 +++++++++
 tb/tb_dz_scan_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/dz_pkg.sv
// dz_pkg: colour codes, FSM states and the 10x8x8 digit glyph table (MSB = leftmost column)
package dz_pkg;
   localparam logic [1:0] DZ_OFF = 2'b00;
   localparam logic [1:0] DZ_RED = 2'b01;
   localparam logic [1:0] DZ_GREEN = 2'b10;
   localparam logic [1:0] DZ_YELLOW = 2'b11;
   localparam logic [7:0] DZ_BLANK = 8'h00;
   typedef enum logic {ST_IDLE, ST_SCAN} dz_state_e;
   localparam logic [7:0] DZ_GLYPHS [10][8] = '{
      '{8'h00, 8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C},
      '{8'h00, 8'h18, 8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h3C},
      '{8'h00, 8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E},
      '{8'h00, 8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C},
      '{8'h00, 8'h0C, 8'h1C, 8'h2C, 8'h4C, 8'h7E, 8'h0C, 8'h0C},
      '{8'h00, 8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C},
      '{8'h00, 8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C},
      '{8'h00, 8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30},
      '{8'h00, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C},
      '{8'h00, 8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38}
   };
endpackage

// File: rtl/dz_scan_ctrl_if.sv
// dz_scan_ctrl_if: digit/colour handshake and matrix pin bundle
// blink is present only when DZ_BLINK_EN is defined
interface dz_scan_ctrl_if #(parameter int ROWS = 8, parameter int COLS = 8);
   logic st;
   logic [3:0] num;
   logic [1:0] color;
   logic num_valid;
   logic num_ready;
   logic [ROWS-1:0] row;
   logic [COLS-1:0] colr;
   logic [COLS-1:0] colg;
   logic frame_start;
`ifdef DZ_BLINK_EN
   logic blink;
   modport master (output st, num, color, num_valid, blink, input num_ready, row, colr, colg, frame_start);
   modport slave (input st, num, color, num_valid, blink, output num_ready, row, colr, colg, frame_start);
`else
   modport master (output st, num, color, num_valid, input num_ready, row, colr, colg, frame_start);
   modport slave (input st, num, color, num_valid, output num_ready, row, colr, colg, frame_start);
`endif
endinterface

// File: rtl/dz_glyph_rom.sv
// dz_glyph_rom: digit and row index to 8-bit glyph row, blank for codes 10..15
module dz_glyph_rom
   import dz_pkg::*;
(
   input  logic [3:0] num_i,
   input  logic [2:0] ridx_i,
   output logic [7:0] pattern_o
);
   assign pattern_o = (num_i < 4'd10) ? DZ_GLYPHS[num_i][ridx_i] : DZ_BLANK;
endmodule

// File: rtl/dz_scan_ctrl.sv
// dz_scan_ctrl: row-scanned bicolour digit display with frame-aligned digit/colour updates
// optional DZ_BLINK_EN adds a blink input that blanks columns every other BLINK_FRAMES frames
module dz_scan_ctrl
   import dz_pkg::*;
#(
   parameter int ROWS = 8,
   parameter int COLS = 8,
   parameter int SCAN_DIV = 1,
   parameter int BLINK_FRAMES = 32
) (
   input  logic clk,
   input  logic rst,
   dz_scan_ctrl_if.slave bus
);
   localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   if (ROWS < 1 || ROWS > 8 || COLS < 1 || COLS > 8 || SCAN_DIV < 1 || BLINK_FRAMES < 1) begin : g_bad_cfg
      $error("dz_scan_ctrl: parameter out of range");
   end
   dz_state_e state_q, state_d;
   logic [2:0] ridx_q, ridx_d;
   logic [DW-1:0] div_q, div_d;
   logic [3:0] dnum_q, dnum_d, pnum_q, pnum_d;
   logic [1:0] dcol_q, dcol_d, pcol_q, pcol_d;
   logic pend_q, pend_d;
   logic [ROWS-1:0] row_q, row_d;
   logic [COLS-1:0] colr_q, colr_d, colg_q, colg_d;
   logic fs_q, fs_d;
   logic [7:0] glyph;
   logic wrap, div_end, apply, dark;
   assign div_end = div_q == DW'(SCAN_DIV - 1);
   assign wrap = state_q == ST_SCAN && div_end && ridx_q == 3'(ROWS - 1);
   always_comb begin
      apply = pend_q && (state_q == ST_IDLE || (wrap && bus.st));
      state_d = bus.st ? ST_SCAN : ST_IDLE;
      div_d = (!bus.st || state_q == ST_IDLE || div_end) ? '0 : div_q + 1'b1;
      ridx_d = (!bus.st || state_q == ST_IDLE || wrap) ? 3'd0 : div_end ? ridx_q + 3'd1 : ridx_q;
      dnum_d = apply ? pnum_q : dnum_q;
      dcol_d = apply ? pcol_q : dcol_q;
      pend_d = apply ? 1'b0 : pend_q || bus.num_valid;
      pnum_d = (!pend_q && bus.num_valid) ? bus.num : pnum_q;
      pcol_d = (!pend_q && bus.num_valid) ? bus.color : pcol_q;
      fs_d = bus.st && (state_q == ST_IDLE || wrap);
      row_d = bus.st ? ~(ROWS'(1) << ridx_d) : '1;
   end
   // columns come from next-state digit and row so they always change together with row
   dz_glyph_rom u_rom (.num_i(dnum_d), .ridx_i(ridx_d), .pattern_o(glyph));
   assign colr_d = (bus.st && !dark && (dcol_d == DZ_RED || dcol_d == DZ_YELLOW)) ? glyph[7 -: COLS] : '0;
   assign colg_d = (bus.st && !dark && (dcol_d == DZ_GREEN || dcol_d == DZ_YELLOW)) ? glyph[7 -: COLS] : '0;
`ifdef DZ_BLINK_EN
   localparam int FW = $clog2(2 * BLINK_FRAMES);
   logic [FW-1:0] fcnt_q, fcnt_d;
   // entry frame is frame 0; count advances only on wrap
   assign fcnt_d = (!bus.st || state_q == ST_IDLE) ? '0 : !wrap ? fcnt_q :
                   (fcnt_q == FW'(2 * BLINK_FRAMES - 1)) ? '0 : fcnt_q + 1'b1;
   assign dark = bus.blink && fcnt_d >= FW'(BLINK_FRAMES);
   always_ff @(posedge clk) fcnt_q <= rst ? '0 : fcnt_d;
`else
   assign dark = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ridx_q <= '0;
         div_q <= '0;
         dnum_q <= '0;
         dcol_q <= DZ_GREEN;
         pend_q <= 1'b0;
         pnum_q <= '0;
         pcol_q <= DZ_OFF;
         row_q <= '1;
         colr_q <= '0;
         colg_q <= '0;
         fs_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ridx_q <= ridx_d;
         div_q <= div_d;
         dnum_q <= dnum_d;
         dcol_q <= dcol_d;
         pend_q <= pend_d;
         pnum_q <= pnum_d;
         pcol_q <= pcol_d;
         row_q <= row_d;
         colr_q <= colr_d;
         colg_q <= colg_d;
         fs_q <= fs_d;
      end
   end
   assign bus.row = row_q;
   assign bus.colr = colr_q;
   assign bus.colg = colg_q;
   assign bus.frame_start = fs_q;
   assign bus.num_ready = ~pend_q;
endmodule

// File: tb/tb_dz_scan_ctrl.sv
// tb_dz_scan_ctrl: directed test-plan checks plus randomized comparison against a frame-level model
module tb_dz_scan_ctrl;
   import dz_pkg::*;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   dz_scan_ctrl_if #(.ROWS(8), .COLS(8)) ia ();
   dz_scan_ctrl_if #(.ROWS(4), .COLS(6)) ib ();
   dz_scan_ctrl #(.ROWS(8), .COLS(8), .SCAN_DIV(1), .BLINK_FRAMES(2)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   dz_scan_ctrl #(.ROWS(4), .COLS(6), .SCAN_DIV(3), .BLINK_FRAMES(2)) dut_b (.clk(clk), .rst(rst), .bus(ib));
   localparam logic [7:0] GL [10][8] = '{
      '{8'h00, 8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C},
      '{8'h00, 8'h18, 8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h3C},
      '{8'h00, 8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E},
      '{8'h00, 8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C},
      '{8'h00, 8'h0C, 8'h1C, 8'h2C, 8'h4C, 8'h7E, 8'h0C, 8'h0C},
      '{8'h00, 8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C},
      '{8'h00, 8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C},
      '{8'h00, 8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30},
      '{8'h00, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C},
      '{8'h00, 8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38}
   };
   int n_pass = 0, n_chk = 0;
   // model: t counts cycles since entering scan; row, frame and boundary follow by arithmetic
   bit m_run[2], m_pend[2];
   int m_t[2];
   logic [3:0] m_dn[2], m_pn[2];
   logic [1:0] m_dc[2], m_pc[2];
   logic [7:0] e_row[2], e_r[2], e_g[2];
   bit e_fs[2];

   task automatic mstep(int k, bit r, bit s, bit v, logic [3:0] n, logic [1:0] c, bit b);
      int nr = k ? 4 : 8, nc = k ? 6 : 8, nd = k ? 3 : 1;
      int fl = nr * nd, ri;
      logic [7:0] mask = 8'((1 << nr) - 1);
      logic [7:0] p;
      if (r) begin
         m_run[k] = 0; m_pend[k] = 0; m_t[k] = 0; m_dn[k] = 0; m_dc[k] = DZ_GREEN;
         e_row[k] = mask; e_r[k] = 0; e_g[k] = 0; e_fs[k] = 0;
         return;
      end
      if (m_pend[k] && (!m_run[k] || (s && (m_t[k] + 1) % fl == 0))) begin
         m_dn[k] = m_pn[k]; m_dc[k] = m_pc[k]; m_pend[k] = 0;
      end else if (v && !m_pend[k]) begin
         m_pend[k] = 1; m_pn[k] = n; m_pc[k] = c;
      end
      m_t[k] = (s && m_run[k]) ? m_t[k] + 1 : 0;
      m_run[k] = s;
      if (!s) begin
         e_row[k] = mask; e_r[k] = 0; e_g[k] = 0; e_fs[k] = 0;
      end else begin
         ri = (m_t[k] / nd) % nr;
         p = (m_dn[k] < 10) ? GL[m_dn[k]][ri] : 8'h00;
         p = p >> (8 - nc);
`ifdef DZ_BLINK_EN
         if (b && ((m_t[k] / fl) % 4) >= 2) p = 8'h00;
`endif
         e_row[k] = mask & ~(8'(1) << ri);
         e_fs[k] = (m_t[k] % fl) == 0;
         e_r[k] = m_dc[k][0] ? p : 8'h00;
         e_g[k] = m_dc[k][1] ? p : 8'h00;
      end
   endtask

   task automatic tick(bit r, bit s, bit v, logic [3:0] n, logic [1:0] c, bit b);
      rst = r;
      ia.st = s; ia.num_valid = v; ia.num = n; ia.color = c;
      ib.st = s; ib.num_valid = v; ib.num = n; ib.color = c;
`ifdef DZ_BLINK_EN
      ia.blink = b; ib.blink = b;
`endif
      @(posedge clk);
      mstep(0, r, s, v, n, c, b);
      mstep(1, r, s, v, n, c, b);
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) tick(1, 1, 1, 4'd5, DZ_YELLOW, 1);
      n_chk++;
      if ({ia.row, ia.colr, ia.colg, ia.frame_start, ia.num_ready} !== {8'hFF, 8'h00, 8'h00, 1'b0, 1'b1})
         $display("FAIL reset_a: got %h/%h/%h/%b/%b want ff/00/00/0/1", ia.row, ia.colr, ia.colg, ia.frame_start, ia.num_ready);
      else n_pass++;
      n_chk++;
      if ({ib.row, ib.colr, ib.colg, ib.frame_start, ib.num_ready} !== {4'hF, 6'h00, 6'h00, 1'b0, 1'b1})
         $display("FAIL reset_b: got %h/%h/%h/%b/%b want f/00/00/0/1", ib.row, ib.colr, ib.colg, ib.frame_start, ib.num_ready);
      else n_pass++;
   endtask

   task automatic test_first_frame();
      tick(0, 0, 1, 4'd1, DZ_GREEN, 0);
      n_chk++;
      if (ia.num_ready !== 1'b0) $display("FAIL idle_accept_ready: got %b want 0", ia.num_ready); else n_pass++;
      tick(0, 0, 0, 4'd1, DZ_GREEN, 0);
      n_chk++;
      if (ia.num_ready !== 1'b1) $display("FAIL idle_apply_ready: got %b want 1", ia.num_ready); else n_pass++;
      tick(0, 1, 0, 4'd1, DZ_GREEN, 0);
      n_chk++;
      if ({ia.row, ia.colr, ia.colg, ia.frame_start} !== {8'hFE, 8'h00, 8'h00, 1'b1})
         $display("FAIL entry_row0: got %h/%h/%h/%b want fe/00/00/1", ia.row, ia.colr, ia.colg, ia.frame_start);
      else n_pass++;
      repeat (3) tick(0, 1, 0, 4'd1, DZ_GREEN, 0);
      n_chk++;
      if ({ia.row, ia.colr, ia.colg, ia.frame_start} !== {8'hF7, 8'h00, 8'h38, 1'b0})
         $display("FAIL digit1_row3: got %h/%h/%h/%b want f7/00/38/0", ia.row, ia.colr, ia.colg, ia.frame_start);
      else n_pass++;
   endtask

   task automatic test_midframe_update();
      tick(0, 1, 1, 4'd2, DZ_YELLOW, 0);
      n_chk++;
      if ({ia.row, ia.num_ready} !== {8'hEF, 1'b0}) $display("FAIL mid_accept: got %h/%b want ef/0", ia.row, ia.num_ready);
      else n_pass++;
      repeat (3) tick(0, 1, 0, 4'd2, DZ_YELLOW, 0);
      n_chk++;
      if ({ia.row, ia.colr, ia.colg, ia.num_ready} !== {8'h7F, 8'h00, 8'h3C, 1'b0})
         $display("FAIL mid_old_row7: got %h/%h/%h/%b want 7f/00/3c/0", ia.row, ia.colr, ia.colg, ia.num_ready);
      else n_pass++;
      tick(0, 1, 0, 4'd2, DZ_YELLOW, 0);
      n_chk++;
      if ({ia.row, ia.frame_start, ia.num_ready} !== {8'hFE, 1'b1, 1'b1})
         $display("FAIL mid_apply: got %h/%b/%b want fe/1/1", ia.row, ia.frame_start, ia.num_ready);
      else n_pass++;
      repeat (7) tick(0, 1, 0, 4'd2, DZ_YELLOW, 0);
      n_chk++;
      if ({ia.row, ia.colr, ia.colg} !== {8'h7F, 8'h7E, 8'h7E})
         $display("FAIL digit2_row7: got %h/%h/%h want 7f/7e/7e", ia.row, ia.colr, ia.colg);
      else n_pass++;
   endtask

   task automatic test_boundary_accept();
      tick(0, 1, 1, 4'd8, DZ_RED, 0);
      n_chk++;
      if ({ia.row, ia.frame_start, ia.num_ready} !== {8'hFE, 1'b1, 1'b0})
         $display("FAIL bnd_accept: got %h/%b/%b want fe/1/0", ia.row, ia.frame_start, ia.num_ready);
      else n_pass++;
      repeat (3) tick(0, 1, 0, 4'd8, DZ_RED, 0);
      n_chk++;
      if ({ia.row, ia.colr, ia.colg} !== {8'hF7, 8'h06, 8'h06})
         $display("FAIL bnd_old_frame: got %h/%h/%h want f7/06/06", ia.row, ia.colr, ia.colg);
      else n_pass++;
      repeat (5) tick(0, 1, 0, 4'd8, DZ_RED, 0);
      n_chk++;
      if ({ia.row, ia.num_ready} !== {8'hFE, 1'b1}) $display("FAIL bnd_apply: got %h/%b want fe/1", ia.row, ia.num_ready);
      else n_pass++;
      repeat (3) tick(0, 1, 0, 4'd8, DZ_RED, 0);
      n_chk++;
      if ({ia.row, ia.colr, ia.colg} !== {8'hF7, 8'h66, 8'h00})
         $display("FAIL bnd_new_frame: got %h/%h/%h want f7/66/00", ia.row, ia.colr, ia.colg);
      else n_pass++;
   endtask

   task automatic test_st_drop();
      repeat (2) tick(0, 1, 0, 4'd8, DZ_RED, 0);
      tick(0, 0, 0, 4'd8, DZ_RED, 0);
      n_chk++;
      if ({ia.row, ia.colr, ia.colg, ia.frame_start} !== {8'hFF, 8'h00, 8'h00, 1'b0})
         $display("FAIL st_drop: got %h/%h/%h/%b want ff/00/00/0", ia.row, ia.colr, ia.colg, ia.frame_start);
      else n_pass++;
      tick(0, 1, 0, 4'd8, DZ_RED, 0);
      n_chk++;
      if ({ia.row, ia.frame_start} !== {8'hFE, 1'b1}) $display("FAIL st_restart: got %h/%b want fe/1", ia.row, ia.frame_start);
      else n_pass++;
   endtask

   task automatic test_div_rows();
      logic [3:0] want;
      tick(1, 0, 0, 4'd0, DZ_OFF, 0);
      tick(0, 0, 1, 4'd12, DZ_YELLOW, 0);
      tick(0, 0, 0, 4'd12, DZ_YELLOW, 0);
      for (int i = 0; i < 24; i++) begin
         tick(0, 1, 0, 4'd12, DZ_YELLOW, 0);
         want = ~(4'd1 << ((i / 3) % 4));
         n_chk++;
         if ({ib.row, ib.colr, ib.colg, ib.frame_start} !== {want, 6'h00, 6'h00, 1'(i % 12 == 0)})
            $display("FAIL div_rows[%0d]: got %h/%h/%h/%b want %h/00/00/%b", i, ib.row, ib.colr, ib.colg, ib.frame_start, want, i % 12 == 0);
         else n_pass++;
      end
   endtask

`ifdef DZ_BLINK_EN
   task automatic test_blink();
      tick(1, 0, 0, 4'd0, DZ_OFF, 1);
      tick(0, 0, 1, 4'd0, DZ_RED, 1);
      tick(0, 0, 0, 4'd0, DZ_RED, 1);
      for (int i = 0; i < 64; i++) begin
         tick(0, 1, 0, 4'd0, DZ_RED, 1);
         if (i % 8 == 1) begin
            n_chk++;
            if (ia.colr !== (((i / 8) % 4 < 2) ? 8'h3C : 8'h00))
               $display("FAIL blink_frame%0d: got %h want %h", i / 8, ia.colr, ((i / 8) % 4 < 2) ? 8'h3C : 8'h00);
            else n_pass++;
         end
      end
   endtask
`endif

   task automatic test_random();
      bit b = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 199) == 0) b = ~b;
         tick($urandom_range(0, 149) == 0, $urandom_range(0, 19) != 0, $urandom_range(0, 3) == 0,
              4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), b);
         n_chk++;
         if ({ia.row, ia.colr, ia.colg, ia.frame_start, ia.num_ready} !== {e_row[0], e_r[0], e_g[0], e_fs[0], !m_pend[0]})
            $display("FAIL rand_a[%0d]: got %h/%h/%h/%b/%b want %h/%h/%h/%b/%b", i, ia.row, ia.colr, ia.colg, ia.frame_start,
                     ia.num_ready, e_row[0], e_r[0], e_g[0], e_fs[0], !m_pend[0]);
         else n_pass++;
         n_chk++;
         if ({ib.row, ib.colr, ib.colg, ib.frame_start, ib.num_ready} !== {e_row[1][3:0], e_r[1][5:0], e_g[1][5:0], e_fs[1], !m_pend[1]})
            $display("FAIL rand_b[%0d]: got %h/%h/%h/%b/%b want %h/%h/%h/%b/%b", i, ib.row, ib.colr, ib.colg, ib.frame_start,
                     ib.num_ready, e_row[1][3:0], e_r[1][5:0], e_g[1][5:0], e_fs[1], !m_pend[1]);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_midframe_update();
      test_boundary_accept();
      test_st_drop();
      test_div_rows();
`ifdef DZ_BLINK_EN
      test_blink();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
